// File: rtl/fp_minmax_reduce_if.sv
// Stream and control bundle for the floating-point min/max reduction unit.
// Handshake: an element moves when in_valid and in_ready are both high on a
// rising clock edge; the master holds in_data stable while in_valid is high,
// in_ready never waits on in_valid, and in_data is don't-care otherwise.
interface fp_minmax_reduce_if #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
);
    logic              start;
    logic              max_n_min;
    logic [LEN_W-1:0]  len;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] res;
    logic [LEN_W-1:0]  res_idx;
    logic              invalid;
    logic              all_nan;

    // Driver side: issues commands and elements, observes results.
    modport master (
        output start, max_n_min, len, in_valid, in_data,
        input  in_ready, busy, done, res, res_idx, invalid, all_nan
    );

    // Reduction unit side.
    modport slave (
        input  start, max_n_min, len, in_valid, in_data,
        output in_ready, busy, done, res, res_idx, invalid, all_nan
    );
endinterface

// File: rtl/fp_minmax_reduce.sv
// Streaming floating-point min/max reduction with minNum/maxNum NaN skipping.
// Returns the winning value, its first-occurrence index, a sticky sNaN flag and
// an all-NaN indication. dbg_state exposes the FSM state (0 IDLE, 1 RUN).
module fp_minmax_reduce #(
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8,
    parameter int LEN_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fp_minmax_reduce_if.slave    bus,
    output logic                 dbg_state
);
    localparam int MANT_W = DATA_W - EXP_W - 1;
    localparam logic [DATA_W-1:0] CANON_NAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              mode_q, mode_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              have_q, have_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic              sinv_q, sinv_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [LEN_W-1:0]  res_idx_q, res_idx_d;
    logic              invalid_q, invalid_d;
    logic              all_nan_q, all_nan_d;

    logic              in_sign, acc_sign;
    logic [DATA_W-2:0] in_mag, acc_mag;
    logic              in_is_nan, in_is_snan;
    logic              cand_gt, cand_lt, cand_better;
    logic              accept;

    // Classify the incoming element and order it against the accumulator.
    always_comb begin
        in_sign    = bus.in_data[DATA_W-1];
        in_mag     = bus.in_data[DATA_W-2:0];
        acc_sign   = acc_q[DATA_W-1];
        acc_mag    = acc_q[DATA_W-2:0];
        in_is_nan  = (&bus.in_data[DATA_W-2 -: EXP_W]) && (|bus.in_data[MANT_W-1:0]);
        in_is_snan = in_is_nan && !bus.in_data[MANT_W-1];
        // Opposite signs: the positive one is bigger, which puts -0 below +0.
        if (in_sign != acc_sign) begin
            cand_gt = !in_sign;
            cand_lt = in_sign;
        end else if (in_sign) begin
            cand_gt = in_mag < acc_mag;
            cand_lt = in_mag > acc_mag;
        end else begin
            cand_gt = in_mag > acc_mag;
            cand_lt = in_mag < acc_mag;
        end
        // Strict comparison so ties keep the earliest index.
        cand_better = mode_q ? cand_gt : cand_lt;
        accept      = bus.in_valid && in_ready_q;
    end

    // Next-state and result computation for the IDLE/RUN controller.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        have_d     = have_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        sinv_d     = sinv_q;
        in_ready_d = in_ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        res_d      = res_q;
        res_idx_d  = res_idx_q;
        invalid_d  = invalid_q;
        all_nan_d  = all_nan_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    len_d  = bus.len;
                    mode_d = bus.max_n_min;
                    cnt_d  = '0;
                    have_d = 1'b0;
                    sinv_d = 1'b0;
                    if (bus.len == '0) begin
                        // Empty vector completes immediately with a NaN result.
                        done_d    = 1'b1;
                        res_d     = CANON_NAN;
                        res_idx_d = '0;
                        all_nan_d = 1'b1;
                        invalid_d = 1'b0;
                    end else begin
                        state_d    = S_RUN;
                        in_ready_d = 1'b1;
                        busy_d     = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (accept) begin
                    cnt_d  = cnt_q + 1'b1;
                    sinv_d = sinv_q | in_is_snan;
                    if (!in_is_nan && (!have_q || cand_better)) begin
                        acc_d  = bus.in_data;
                        idx_d  = cnt_q;
                        have_d = 1'b1;
                    end
                    if (cnt_d == len_q) begin
                        state_d    = S_IDLE;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        res_d      = have_d ? acc_d : CANON_NAN;
                        res_idx_d  = have_d ? idx_d : '0;
                        invalid_d  = sinv_d;
                        all_nan_d  = !have_d;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; synchronous active-low reset drops any partial run.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            mode_q     <= 1'b0;
            cnt_q      <= '0;
            have_q     <= 1'b0;
            acc_q      <= '0;
            idx_q      <= '0;
            sinv_q     <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            res_q      <= '0;
            res_idx_q  <= '0;
            invalid_q  <= 1'b0;
            all_nan_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            have_q     <= have_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            sinv_q     <= sinv_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            res_q      <= res_d;
            res_idx_q  <= res_idx_d;
            invalid_q  <= invalid_d;
            all_nan_q  <= all_nan_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.res      = res_q;
    assign bus.res_idx  = res_idx_q;
    assign bus.invalid  = invalid_q;
    assign bus.all_nan  = all_nan_q;
    assign dbg_state    = state_q;
endmodule

// File: doc/fp_minmax_reduce.md
# fp_minmax_reduce

Streaming floating-point min/max reduction unit in the FPU datapath. Generalises the two-operand min/max to a vector of `len` operands delivered on a valid/ready stream. Returns the selected value and its index, an IEEE 754-2008 invalid flag for signalling NaNs, and an all-NaN indication. It sits beside the scalar FP units and is driven by the same start/done control style.

## Interface
- `DATA_W`, 32, total float width (sign + exponent + mantissa)
- `EXP_W`, 8, exponent width; mantissa width is `DATA_W-EXP_W-1`
- `LEN_W`, 16, width of the element count and of the index
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-low; 0 means reset on the next rising edge.
- `start` input 1: begin a reduction; sampled only in IDLE.
- `max_n_min` input 1: 1 selects max, 0 selects min; latched at start.
- `len` input LEN_W: number of elements; latched at start.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: unit accepts an element this cycle.
- `in_data` input DATA_W: element.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse when results are valid.
- `res` output DATA_W: selected value; held until the next start.
- `res_idx` output LEN_W: 0-based index of `res` within the vector.
- `invalid` output 1: at least one signalling NaN was seen.
- `all_nan` output 1: no non-NaN element was seen, or `len`=0.

## Operation
- NaN: exponent all ones and mantissa ≠ 0.
- sNaN: a NaN whose mantissa MSB is 0.
- Canonical NaN: {0, all-ones exponent, 1, zeros}; 0x7FC00000 at 32 bits.
- Ordering between non-NaN operands:
  - Different sign: the positive operand is bigger, so -0 < +0.
  - Same sign: compare `{exp,mant}` unsigned; a larger magnitude is bigger when positive and smaller when negative.
- NaN elements are skipped (minNum/maxNum semantics) and never update the accumulator.
- A candidate replaces the accumulator only if it is strictly better, so ties keep the earliest index.
- The first non-NaN element always loads the accumulator.
- FSM states:
  - IDLE: `in_ready`=0, `busy`=0. On `start`:
    - Latch `len` and `max_n_min`.
    - Clear the count, the "have value" flag, and the sticky invalid flag.
    - If `len`=0: stay in IDLE and pulse `done` next cycle with `res`=canonical NaN, `res_idx`=0, `all_nan`=1, `invalid`=0.
    - Otherwise go to RUN.
  - RUN: `in_ready`=1, `busy`=1.
    - An element is accepted on `in_valid & in_ready`.
    - On each accept: increment the count, update the accumulator and index, and OR in the sNaN status.
    - When the accepted element is number `len`, return to IDLE and register the results.
- Result registration:
  - `res` is the accumulator, or canonical NaN if no non-NaN element was seen.
  - `all_nan` = !have_value.
  - `invalid` includes the last element.
- `start` in RUN is ignored; the `len` and mode latched at the original start are kept.
- Internal element counter and index are LEN_W wide. The maximum vector is 2^LEN_W−1 elements, so the counter never wraps.
- `in_data` is ignored whenever `in_ready`=0.

## Timing
- Reset values: `in_ready`=0, `busy`=0, `done`=0, `res`=0, `res_idx`=0, `invalid`=0, `all_nan`=0, state IDLE.
- `in_ready` and `busy` go high the cycle after `start` is sampled in IDLE with `len`≠0.
- Throughput: one element per cycle; `in_valid` bubbles stall without side effects.
- `done` rises the cycle after the last element is accepted, and `in_ready` falls in that same cycle.
- `res`, `res_idx`, `invalid` and `all_nan` change only in the cycle `done` rises, and hold until the next `done`.
- `start` may be asserted in the same cycle `done` is high; RUN is re-entered the next cycle. Minimum gap: 0 idle cycles.
- Reset mid-RUN: return to IDLE and discard partial state. All outputs take their reset values on the next edge, and no `done` is issued.

## Test plan
- Max over {0x3F800000, 0xC0000000, 0x40400000, 0x40000000} with `len`=4 and continuous valid → `done` 5 cycles after start, `res`=0x40400000, `res_idx`=2, `invalid`=0, `all_nan`=0.
- Min over {0x00000000, 0x80000000, 0x80000000} → `res`=0x80000000, `res_idx`=1 (tie keeps the first occurrence), proving -0 < +0.
- Min over {0x7FC00001, 0x7F800001, 0x41200000} → `res`=0x41200000, `res_idx`=2, `invalid`=1 (sNaN at index 1), `all_nan`=0.
- Max over {0xFFC00000, 0x7F800001} → `res`=0x7FC00000, `all_nan`=1, `invalid`=1. Separately, `len`=0 → `done` the next cycle, `res`=0x7FC00000, `all_nan`=1.
- Random `in_valid` gaps with a `start` pulse during RUN, then back-to-back `start` in the `done` cycle → results match the software model, and the mid-RUN start has no effect.
- `rst`=0 after 2 of 4 elements are accepted → all outputs return to 0 next cycle and no `done` appears. A new 1-element run of 0x3F800000 then gives `res`=0x3F800000, `res_idx`=0.
